// File: rtl/memory_pkg.sv
// Shared constants for the memory block.
// Holds the ROM preload table and its lookup helper.
package memory_pkg;

   localparam logic [7:0] ROM_INIT_0 = 8'hAA;
   localparam logic [7:0] ROM_INIT_1 = 8'hBB;
   localparam logic [7:0] ROM_INIT_2 = 8'hCC;
   localparam int unsigned ROM_INIT_COUNT = 3;

   // Preload value for word idx; zero past the table.
   function automatic logic [7:0] rom_init(input logic [31:0] idx);
      logic [7:0] v;
      v = 8'h00;
      case (idx)
         32'd0:   v = ROM_INIT_0;
         32'd1:   v = ROM_INIT_1;
         32'd2:   v = ROM_INIT_2;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/memory_array.sv
// Storage core: array, write port and registered read.
// Out-of-range reads return zero; writes arrive pre-qualified.
module memory_array
   import memory_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int IS_RAM     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  in_range,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [IW-1:0] idx;
   assign idx = addr[IW-1:0];

   generate
      if (IS_RAM != 0) begin : g_ram
         logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

         // Write port; contents are never touched by reset.
         always_ff @(posedge clk) begin
            if (we) mem[idx] <= data_in;
         end

         // Read-first registered read, cleared asynchronously.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        rd_data <= '0;
            else if (in_range) rd_data <= mem[idx];
            else               rd_data <= '0;
         end
      end else begin : g_rom
         logic unused_rom;
         assign unused_rom = &{1'b0, we, data_in};

         // Registered lookup into the fixed preload table.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               rd_data <= '0;
            else if (in_range)
               rd_data <= DATA_WIDTH'(rom_init(32'(idx)));
            else
               rd_data <= '0;
         end
      end
   endgenerate

endmodule

// File: rtl/memory.sv
// Single-port synchronous RAM/ROM, selected by IS_RAM.
// Checks parameters, gates writes and range-checks addresses.
module memory
   import memory_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int IS_RAM     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] data_out
);

   generate
      if (MEM_DEPTH < 1 ||
          64'(MEM_DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_bad
         $fatal(1, "memory: MEM_DEPTH out of range");
      end
   endgenerate

   logic in_range;
   logic we_ok;

   assign in_range = {1'b0, addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH);
   assign we_ok    = (IS_RAM != 0) && (we == 1'b1)
                     && in_range && rst_n;

   memory_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IS_RAM     (IS_RAM)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .in_range (in_range),
      .data_in  (data_in),
      .we       (we_ok),
      .rd_data  (data_out)
   );

   a_we_known: assert property (
      @(posedge clk) disable iff (!rst_n) !$isunknown(we)
   );

endmodule

// File: tb/tb_memory.sv
// Bench for memory: RAM, ROM and a shallow RAM side by side.
// A per-instance word model is checked every cycle.
module tb_memory;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic       we = 1'b0;
   logic [7:0] out_ram;
   logic [7:0] out_rom;
   logic [7:0] out_sml;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   memory #(.IS_RAM(1)) u_ram (
      .clk(clk), .rst_n(rst_n), .addr(addr),
      .data_in(data_in), .we(we), .data_out(out_ram)
   );

   memory #(.IS_RAM(0)) u_rom (
      .clk(clk), .rst_n(rst_n), .addr(addr),
      .data_in(data_in), .we(we), .data_out(out_rom)
   );

   memory #(.MEM_DEPTH(16), .IS_RAM(1)) u_sml (
      .clk(clk), .rst_n(rst_n), .addr(addr),
      .data_in(data_in), .we(we), .data_out(out_sml)
   );

   // Word-level model of the three instances.
   int m_ram [256];
   int m_sml [16];
   int e_ram = 0;
   int e_rom = 0;
   int e_sml = 0;

   function automatic int rom_word(input int a);
      if (a == 0) return 'hAA;
      if (a == 1) return 'hBB;
      if (a == 2) return 'hCC;
      return 0;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) m_ram[i] = 0;
      for (int i = 0; i < 16; i++) m_sml[i] = 0;
   end

   // Model: read old contents, then apply the write.
   always @(posedge clk) begin
      if (rst_n) begin
         e_ram = m_ram[addr];
         e_rom = rom_word(int'(addr));
         e_sml = (addr < 16) ? m_sml[addr[3:0]] : 0;
         if (we) begin
            m_ram[addr] = int'(data_in);
            if (addr < 16) m_sml[addr[3:0]] = int'(data_in);
         end
      end
   end

   always @(negedge rst_n) begin
      e_ram = 0;
      e_rom = 0;
      e_sml = 0;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("model_ram", int'(out_ram), e_ram);
      chk("model_rom", int'(out_rom), e_rom);
      chk("model_sml", int'(out_sml), e_sml);
   end

   task automatic cyc(input logic [7:0] a, input logic [7:0] d,
                      input logic w);
      addr = a;
      data_in = d;
      we = w;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ram", int'(out_ram), 0);
      chk("rst_rom", int'(out_rom), 0);
      chk("rst_sml", int'(out_sml), 0);
      rst_n = 1'b1;

      cyc(8'h00, 8'h55, 1'b1);
      cyc(8'h01, 8'h66, 1'b1);
      cyc(8'h02, 8'h77, 1'b1);
      cyc(8'h00, 8'h00, 1'b0);
      chk("ram_rd0", int'(out_ram), 'h55);
      chk("rom_rd0", int'(out_rom), 'hAA);
      cyc(8'h01, 8'h00, 1'b0);
      chk("ram_rd1", int'(out_ram), 'h66);
      chk("rom_rd1", int'(out_rom), 'hBB);
      cyc(8'h02, 8'h00, 1'b0);
      chk("ram_rd2", int'(out_ram), 'h77);
      chk("rom_rd2", int'(out_rom), 'hCC);
      cyc(8'h03, 8'h00, 1'b0);
      chk("rom_rd3", int'(out_rom), 'h00);

      cyc(8'h00, 8'h12, 1'b1);
      cyc(8'h00, 8'h00, 1'b0);
      chk("rom_nowr", int'(out_rom), 'hAA);
      chk("ram_wr12", int'(out_ram), 'h12);

      cyc(8'h10, 8'h55, 1'b1);
      cyc(8'h10, 8'h99, 1'b1);
      chk("rdw_old", int'(out_ram), 'h55);
      cyc(8'h10, 8'h00, 1'b0);
      chk("rdw_new", int'(out_ram), 'h99);

      cyc(8'h01, 8'h00, 1'b0);
      chk("pre_rst", int'(out_ram), 'h66);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_ram", int'(out_ram), 0);
      chk("async_rom", int'(out_rom), 0);
      chk("async_sml", int'(out_sml), 0);
      cyc(8'h01, 8'hEE, 1'b1);
      cyc(8'h01, 8'hEE, 1'b1);
      chk("rst_hold", int'(out_ram), 0);
      we = 1'b0;
      rst_n = 1'b1;
      cyc(8'h01, 8'h00, 1'b0);
      chk("kept_1", int'(out_ram), 'h66);
      chk("kept_sml", int'(out_sml), 'h66);

      cyc(8'h20, 8'hAB, 1'b1);
      cyc(8'h20, 8'h00, 1'b0);
      chk("oor_sml", int'(out_sml), 'h00);
      chk("oor_ram", int'(out_ram), 'hAB);
      cyc(8'h00, 8'h00, 1'b0);
      chk("noalias", int'(out_sml), 'h12);
      cyc(8'h10, 8'h00, 1'b0);
      chk("oor_rdw", int'(out_sml), 'h00);
      cyc(8'h0F, 8'h3C, 1'b1);
      cyc(8'h0F, 8'h00, 1'b0);
      chk("top_word", int'(out_sml), 'h3C);

      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 3; a++) begin
            cyc(8'(a), 8'h00, 1'b0);
         end
      end
      cyc(8'h02, 8'h00, 1'b0);
      chk("lat_rom", int'(out_rom), 'hCC);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Parameterised single-port synchronous memory. Built as a writable RAM or a preloaded read-only ROM, selected by the IS_RAM parameter.
- Used as a generic on-chip storage block: RAM for scratch data, ROM for constant tables.
- Same port list in both modes, so instances are interchangeable.

Parameters:
- DATA_WIDTH, 8, width of each word in bits.
- ADDR_WIDTH, 8, width of the address bus.
- MEM_DEPTH, 256, number of words; legal range 1 to 2**ADDR_WIDTH.
- IS_RAM, 1, 1 builds a writable RAM; 0 builds a ROM with fixed contents.

Ports:
- clk  input  1  Rising-edge clock for all state.
- rst_n  input  1  Asynchronous active-low reset.
- addr  input  ADDR_WIDTH  Word address for both read and write.
- data_in  input  DATA_WIDTH  Write data; used only when IS_RAM=1.
- we  input  1  Write enable, active-high; ignored when IS_RAM=0.
- data_out  output  DATA_WIDTH  Registered read data.

Behaviour:
- Single clock domain clk. Reset rst_n is asynchronous and active-low.
- Reset:
  - While rst_n=0, data_out=0, forced immediately with no clock edge.
  - Reset does not modify array contents.
  - The first read after reset release is on the first rising edge with rst_n=1.
- Read path:
  - Synchronous, latency 1.
  - On each rising edge with rst_n=1, data_out <= mem[addr].
  - data_out holds its value between edges. There is no read enable; a read occurs every cycle.
- Write path (IS_RAM=1 only):
  - On a rising edge with we=1 and rst_n=1, mem[addr] <= data_in.
  - One write per cycle.
- Read-during-write, same address, same edge: read-first. data_out gets the old contents; the new data is visible on the next edge.
- ROM mode (IS_RAM=0):
  - we and data_in are ignored and contents never change.
  - Initial contents: word 0 = 8'hAA, word 1 = 8'hBB, word 2 = 8'hCC, all other words 0.
  - For DATA_WIDTH other than 8, these values are zero-extended or truncated.
  - Words beyond MEM_DEPTH-1 are not created.
- RAM initial contents: all words 0 at time zero, via array initialisation rather than reset.
- Out-of-range address (addr >= MEM_DEPTH, possible only when MEM_DEPTH < 2**ADDR_WIDTH):
  - A write is dropped with no aliasing.
  - A read returns 0 on the next edge.
- Reset asserted mid-operation:
  - data_out clears at once.
  - A write on the same edge as reset assertion does not occur.
- X or Z on we is treated as no write in RAM mode. Simulation flags it with an assertion.
- Elaboration check: MEM_DEPTH > 2**ADDR_WIDTH or MEM_DEPTH < 1 is a fatal parameter error.

Decomposition:
- Shared package memory_pkg holds:
  - ROM preload constants ROM_INIT_0/1/2 (8'hAA, 8'hBB, 8'hCC).
  - A ROM_INIT_COUNT constant (3).
  - A function returning the preload value for a given index (0 beyond the table).
- One natural sub-module: memory_array, the storage core.
  - It holds the array, write port and registered read.
  - The top-level memory handles parameter checks, IS_RAM gating of we, range checking and reset of data_out.

Test Plan:
- RAM basic: IS_RAM=1, reset then release. Write 0x55@0x00, 0x66@0x01, 0x77@0x02 on consecutive edges, drop we, read 0x00/0x01/0x02 -> data_out = 0x55, 0x66, 0x77, each one edge after its address is applied.
- ROM contents: IS_RAM=0, read 0x00, 0x01, 0x02, 0x03 -> 0xAA, 0xBB, 0xCC, 0x00. Then attempt write 0x12@0x00 with we=1 and re-read -> still 0xAA.
- Read-during-write: RAM holds 0x55@0x10. Write 0x99@0x10 with addr held -> data_out=0x55 after that edge, 0x99 after the next edge.
- Async reset: data_out=0x66, drive rst_n=0 between edges -> data_out=0 immediately, before any edge. Release and read 0x01 -> 0x66, contents preserved.
- Out-of-range: MEM_DEPTH=16, ADDR_WIDTH=8. Write 0xAB@0x20 -> read 0x20 returns 0x00, read 0x00 is unchanged (no aliasing).
- Latency/hold: change addr every cycle across 0x00..0x02 -> each data_out value appears exactly one edge later and is stable between edges.
